// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard gating ID->EX issue.
// Also drives the IF/ID/EX/MEM flush controls and a stall counter.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int RA_W   = $clog2(NREG),
  parameter int LAT_W  = 3,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rj,
  input  logic [RA_W-1:0]   id_rk,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_use_rj,
  input  logic              id_use_rk,
  input  logic              id_use_rd,
  input  logic              id_early,
  input  logic              id_wen,
  input  logic [RA_W-1:0]   id_wdest,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              long_done,
  input  logic [RA_W-1:0]   long_done_rd,
  input  logic              pipe_advance,
  input  logic              branch_redirect,
  input  logic              flush_mem,
  input  logic              flush_wb,
  output logic              id_write_en,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [LAT_W-1:0] LAT_LONG = '1;

  logic [LAT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  lng;

  logic haz_rj;
  logic haz_rk;
  logic haz_rd;
  logic waw;
  logic stall;
  logic flush;
  logic issue;

  // An early consumer reads in ID, one stage before EX forwarding.
  function automatic logic src_haz(
    input logic [RA_W-1:0] r,
    input logic            use_r,
    input logic            early
  );
    logic busy;
    busy = early ? (cnt[r] != '0) : (cnt[r] > LAT_W'(1));
    return use_r && (r != '0) && (lng[r] || busy);
  endfunction

  assign haz_rj = src_haz(id_rj, id_use_rj, id_early);
  assign haz_rk = src_haz(id_rk, id_use_rk, id_early);
  assign haz_rd = src_haz(id_rd, id_use_rd, id_early);
  assign waw    = id_wen && (id_wdest != '0) && lng[id_wdest];
  assign stall  = id_valid && (haz_rj || haz_rk || haz_rd || waw);
  assign flush  = flush_mem || flush_wb;
  assign issue  = id_valid && id_write_en && id_wen &&
                  (id_wdest != '0);

  always_comb begin
    id_write_en = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_flush   = flush_wb;
    if (reset) begin
      id_write_en = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      ex_flush    = 1'b1;
      mem_flush   = 1'b1;
    end else if (flush) begin
      id_write_en = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      ex_flush    = 1'b1;
    end else if (stall) begin
      id_write_en = 1'b0;
      ex_flush    = 1'b1;
    end else begin
      id_flush    = branch_redirect;
    end
  end

  // Priority chain: flush > issue > long_done > countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      lng          <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (flush) begin
          cnt[i] <= '0;
          lng[i] <= 1'b0;
        end else if (issue && id_wdest == RA_W'(i)) begin
          if (id_lat == LAT_LONG) begin
            cnt[i] <= '0;
            lng[i] <= 1'b1;
          end else begin
            cnt[i] <= id_lat + LAT_W'(1);
            lng[i] <= 1'b0;
          end
        end else if (long_done && long_done_rd == RA_W'(i)) begin
          cnt[i] <= LAT_W'(1);
          lng[i] <= 1'b0;
        end else if (pipe_advance && !lng[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LAT_W'(1);
        end
      end
      if (stall && !flush && !(&stall_cycles))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus random traffic checked against
// a per-register ready-time model of the scoreboard.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int RA_W     = 5;
  localparam int LAT_W    = 3;
  localparam int PERF_W   = 32;
  localparam int LAT_LONG = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [RA_W-1:0]   id_rj;
  logic [RA_W-1:0]   id_rk;
  logic [RA_W-1:0]   id_rd;
  logic              id_use_rj;
  logic              id_use_rk;
  logic              id_use_rd;
  logic              id_early;
  logic              id_wen;
  logic [RA_W-1:0]   id_wdest;
  logic [LAT_W-1:0]  id_lat;
  logic              long_done;
  logic [RA_W-1:0]   long_done_rd;
  logic              pipe_advance;
  logic              branch_redirect;
  logic              flush_mem;
  logic              flush_wb;
  logic              id_write_en;
  logic              if_flush;
  logic              id_flush;
  logic              ex_flush;
  logic              mem_flush;
  logic [PERF_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .RA_W(RA_W), .LAT_W(LAT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rj(id_rj),
    .id_rk(id_rk),
    .id_rd(id_rd),
    .id_use_rj(id_use_rj),
    .id_use_rk(id_use_rk),
    .id_use_rd(id_use_rd),
    .id_early(id_early),
    .id_wen(id_wen),
    .id_wdest(id_wdest),
    .id_lat(id_lat),
    .long_done(long_done),
    .long_done_rd(long_done_rd),
    .pipe_advance(pipe_advance),
    .branch_redirect(branch_redirect),
    .flush_mem(flush_mem),
    .flush_wb(flush_wb),
    .id_write_en(id_write_en),
    .if_flush(if_flush),
    .id_flush(id_flush),
    .ex_flush(ex_flush),
    .mem_flush(mem_flush),
    .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles of advance left before a value is forwardable,
  // plus a flag for results of unknown latency.
  int     rem  [NREG];
  bit     pend [NREG];
  longint m_stalls;
  bit     e_stall;
  bit     e_issue;
  bit     e_fl;
  logic   last_wen;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit src_haz(int r, bit u, bit early);
    if (!u || r == 0) return 1'b0;
    if (pend[r]) return 1'b1;
    return early ? (rem[r] > 0) : (rem[r] > 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      rem[i]  = 0;
      pend[i] = 1'b0;
    end
  endtask

  task automatic set_idle();
    reset = 1'b0; id_valid = 1'b0;
    id_rj = '0; id_rk = '0; id_rd = '0;
    id_use_rj = 1'b0; id_use_rk = 1'b0; id_use_rd = 1'b0;
    id_early = 1'b0; id_wen = 1'b0; id_wdest = '0; id_lat = '0;
    long_done = 1'b0; long_done_rd = '0; pipe_advance = 1'b1;
    branch_redirect = 1'b0; flush_mem = 1'b0; flush_wb = 1'b0;
  endtask

  task automatic step();
    logic e_wen, e_if, e_id, e_ex, e_mem;
    #1;
    e_fl    = flush_mem || flush_wb;
    e_stall = id_valid && (
      src_haz(int'(id_rj), id_use_rj, id_early) ||
      src_haz(int'(id_rk), id_use_rk, id_early) ||
      src_haz(int'(id_rd), id_use_rd, id_early) ||
      (id_wen && id_wdest != 0 && pend[id_wdest]));
    e_mem = flush_wb;
    if (reset) begin
      e_wen = 0; e_if = 1; e_id = 1; e_ex = 1; e_mem = 1;
    end else if (e_fl) begin
      e_wen = 0; e_if = 1; e_id = 1; e_ex = 1;
    end else if (e_stall) begin
      e_wen = 0; e_if = 0; e_id = 0; e_ex = 1;
    end else begin
      e_wen = 1; e_if = 0; e_id = branch_redirect; e_ex = 0;
    end
    e_issue = id_valid && e_wen && id_wen && id_wdest != 0;
    chk("id_write_en", 64'(id_write_en), 64'(e_wen));
    chk("if_flush", 64'(if_flush), 64'(e_if));
    chk("id_flush", 64'(id_flush), 64'(e_id));
    chk("ex_flush", 64'(ex_flush), 64'(e_ex));
    chk("mem_flush", 64'(mem_flush), 64'(e_mem));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    last_wen = id_write_en;
    @(posedge clk);
    if (reset) begin
      model_clear();
      m_stalls = 0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (pipe_advance && !pend[i] && rem[i] > 0) rem[i]--;
      if (long_done && long_done_rd != 0) begin
        rem[long_done_rd]  = 1;
        pend[long_done_rd] = 1'b0;
      end
      if (e_issue) begin
        if (int'(id_lat) == LAT_LONG) begin
          rem[id_wdest]  = 0;
          pend[id_wdest] = 1'b1;
        end else begin
          rem[id_wdest]  = int'(id_lat) + 1;
          pend[id_wdest] = 1'b0;
        end
      end
      if (e_fl) model_clear();
      if (e_stall && !e_fl && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
    @(negedge clk);
  endtask

  task automatic producer(input int r, input int lat);
    set_idle();
    id_valid = 1'b1; id_wen = 1'b1;
    id_wdest = RA_W'(r); id_lat = LAT_W'(lat);
    step();
    chk("producer_issue", 64'(last_wen), 64'(1));
  endtask

  task automatic consume(input int r, input bit early,
                         input int freeze, output int stalls);
    set_idle();
    id_valid = 1'b1; id_use_rj = 1'b1;
    id_rj = RA_W'(r); id_early = early;
    stalls = 0;
    for (int k = 0; k < 30; k++) begin
      pipe_advance = (k >= freeze);
      step();
      if (last_wen) return;
      stalls++;
    end
  endtask

  initial begin
    int s;
    int q[$];
    model_clear();
    m_stalls = 0;
    set_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    producer(5, 1);
    consume(5, 0, 0, s);
    chk("load_alu_stalls", 64'(s), 64'(1));
    chk("load_alu_perf", 64'(stall_cycles), 64'(1));

    producer(7, 0);
    consume(7, 1, 0, s);
    chk("alu_branch_stalls", 64'(s), 64'(1));
    producer(7, 1);
    consume(7, 1, 0, s);
    chk("load_branch_stalls", 64'(s), 64'(2));

    producer(9, LAT_LONG);
    set_idle();
    id_valid = 1'b1; id_wen = 1'b1; id_wdest = 5'd9; id_lat = '0;
    step();
    chk("waw_stall", 64'(last_wen), 64'(0));
    set_idle();
    id_valid = 1'b1; id_use_rj = 1'b1; id_rj = 5'd9;
    s = 0;
    for (int k = 2; k <= 12; k++) begin
      long_done = (k == 12); long_done_rd = 5'd9;
      step();
      if (!last_wen) s++;
    end
    long_done = 1'b0;
    step();
    chk("div_stalls", 64'(s), 64'(11));
    chk("div_issue_c13", 64'(last_wen), 64'(1));

    producer(4, 1);
    consume(4, 0, 3, s);
    chk("freeze_stalls", 64'(s), 64'(4));

    producer(0, 1);
    consume(0, 1, 0, s);
    chk("r0_stalls", 64'(s), 64'(0));

    set_idle();
    id_valid = 1'b1; branch_redirect = 1'b1;
    #1;
    chk("redir_id_flush", 64'(id_flush), 64'(1));
    chk("redir_ex_flush", 64'(ex_flush), 64'(0));
    step();

    producer(9, LAT_LONG);
    set_idle();
    id_valid = 1'b1; id_wen = 1'b1; id_wdest = 5'd3; id_lat = 3'd1;
    flush_mem = 1'b1;
    #1;
    chk("fl_if", 64'(if_flush), 64'(1));
    chk("fl_id", 64'(id_flush), 64'(1));
    chk("fl_ex", 64'(ex_flush), 64'(1));
    chk("fl_wen", 64'(id_write_en), 64'(0));
    step();
    set_idle();
    id_valid = 1'b1; id_use_rj = 1'b1; id_rj = 5'd9;
    id_use_rk = 1'b1; id_rk = 5'd3;
    #1;
    chk("post_flush_wen", 64'(id_write_en), 64'(1));
    step();

    set_idle();
    flush_wb = 1'b1;
    #1;
    chk("wb_mem_flush", 64'(mem_flush), 64'(1));
    step();

    for (int n = 0; n < 3000; n++) begin
      set_idle();
      reset     = ($urandom_range(0, 199) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_rj     = RA_W'($urandom_range(0, 7));
      id_rk     = RA_W'($urandom_range(0, 7));
      id_rd     = RA_W'($urandom_range(0, 7));
      id_use_rj = ($urandom_range(0, 1) == 1);
      id_use_rk = ($urandom_range(0, 2) == 0);
      id_use_rd = ($urandom_range(0, 3) == 0);
      id_early  = ($urandom_range(0, 3) == 0);
      id_wen    = ($urandom_range(0, 1) == 1);
      id_wdest  = RA_W'($urandom_range(0, 7));
      id_lat    = LAT_W'($urandom_range(0, 7));
      pipe_advance    = ($urandom_range(0, 4) != 0);
      branch_redirect = ($urandom_range(0, 7) == 0);
      flush_mem = ($urandom_range(0, 39) == 0);
      flush_wb  = ($urandom_range(0, 39) == 0);
      q = {};
      for (int r = 1; r < NREG; r++) if (pend[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
        long_done    = 1'b1;
        long_done_rd = RA_W'(q[$urandom_range(0, q.size() - 1)]);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
